num_to_str: RTL

NUM_TO_STR -- requirements
Module: num_to_str

---
 rtl/num_to_str.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/num_to_str.sv
// -----------------------------------------------------------------------------
// num_to_str
// Converts a 32-bit number into its decimal ASCII representation.
// The output is a byte stream: optional "-", the digits most significant
// first with leading zeros suppressed, then the TERM byte.
// Binary-to-BCD conversion uses shift-and-add-3, one bit per cycle.
//
// Optional feature: define NUM_TO_STR_SIGNED_EN to treat n_dtm as two's
// complement. Negative values then emit a leading "-".
// Without the macro, n_dtm is unsigned and no sign logic exists.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst_n  in   1   synchronous active-low reset
//   n_dtm  in  32   number to convert
//   n_vld  in   1   n_dtm valid
//   n_rdy  out  1   ready to accept a number (IDLE only)
//   s_dtm  out  8   ASCII output byte
//   s_vld  out  1   s_dtm valid
//   s_rdy  in   1   downstream ready for a byte
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module num_to_str #(
    parameter logic [7:0] TERM = 8'h0A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] n_dtm,
    input  logic        n_vld,
    output logic        n_rdy,
    output logic [7:0]  s_dtm,
    output logic        s_vld,
    input  logic        s_rdy
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        CONVERT     = 3'd1,
        EMIT_SIGN   = 3'd2,
        EMIT_DIGITS = 3'd3,
        EMIT_TERM   = 3'd4
    } state_t;

    state_t       state_r, state_nxt_s;
    logic [31:0]  bin_r, bin_nxt_s;
    logic [39:0]  bcd_r, bcd_nxt_s;
    logic [4:0]   cnt_r, cnt_nxt_s;
    logic [3:0]   dig_r, dig_nxt_s;
    logic [7:0]   s_dtm_r, s_dtm_nxt_s;
    logic         s_vld_r, s_vld_nxt_s;
    logic         n_rdy_r, n_rdy_nxt_s;
    logic [39:0]  bcd_step_s;
    logic [3:0]   lead_s;
    logic         sign_pend_s;
    logic [31:0]  mag_s;

    // One double-dabble step: add 3 to every digit >= 5, then shift in a bit.
    function automatic logic [39:0] dd_step(input logic [39:0] bcd, input logic bit_in);
        logic [39:0] adj;
        adj = bcd;
        for (int i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return {adj[38:0], bit_in};
    endfunction

    // Index of the most significant non-zero digit.
    // Returns 0 when the value is zero, so a single "0" is emitted.
    function automatic logic [3:0] lead_idx(input logic [39:0] bcd);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // ASCII code of the BCD digit at position idx.
    function automatic logic [7:0] digit_ascii(input logic [39:0] bcd, input logic [3:0] idx);
        logic [5:0] base;
        base = {idx, 2'b00};
        return 8'h30 + {4'h0, bcd[base +: 4]};
    endfunction

`ifdef NUM_TO_STR_SIGNED_EN
    logic neg_r, neg_nxt_s;
    assign sign_pend_s = neg_r;
    assign mag_s       = n_dtm[31] ? (~n_dtm + 32'd1) : n_dtm;
`else
    assign sign_pend_s = 1'b0;
    assign mag_s       = n_dtm;
`endif

    assign bcd_step_s = dd_step(bcd_r, bin_r[31]);
    assign lead_s     = lead_idx(bcd_step_s);

    assign n_rdy = n_rdy_r;
    assign s_dtm = s_dtm_r;
    assign s_vld = s_vld_r;

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_nxt_s = state_r;
        bin_nxt_s   = bin_r;
        bcd_nxt_s   = bcd_r;
        cnt_nxt_s   = cnt_r;
        dig_nxt_s   = dig_r;
        s_dtm_nxt_s = s_dtm_r;
`ifdef NUM_TO_STR_SIGNED_EN
        neg_nxt_s   = neg_r;
`endif
        case (state_r)
            IDLE: begin
                if (n_vld) begin
                    state_nxt_s = CONVERT;
                    bin_nxt_s   = mag_s;
                    bcd_nxt_s   = 40'd0;
                    cnt_nxt_s   = 5'd0;
`ifdef NUM_TO_STR_SIGNED_EN
                    neg_nxt_s   = n_dtm[31];
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CONVERT: begin
                bcd_nxt_s = bcd_step_s;
                bin_nxt_s = {bin_r[30:0], 1'b0};
                if (cnt_r == 5'd31) begin
                    // Last shift: the first byte is computed from the final BCD
                    // value so it appears on the same edge as s_vld.
                    cnt_nxt_s = 5'd0;
                    dig_nxt_s = lead_s;
                    if (sign_pend_s) begin
                        state_nxt_s = EMIT_SIGN;
                        s_dtm_nxt_s = 8'h2D;
                    end else begin
                        state_nxt_s = EMIT_DIGITS;
                        s_dtm_nxt_s = digit_ascii(bcd_step_s, lead_s);
                    end
                end else begin
                    cnt_nxt_s = cnt_r + 5'd1;
                end
            end
            EMIT_SIGN: begin
                if (s_rdy) begin
                    state_nxt_s = EMIT_DIGITS;
                    s_dtm_nxt_s = digit_ascii(bcd_r, dig_r);
                end else begin
                    state_nxt_s = EMIT_SIGN;
                end
            end
            EMIT_DIGITS: begin
                if (s_rdy) begin
                    if (dig_r == 4'd0) begin
                        state_nxt_s = EMIT_TERM;
                        s_dtm_nxt_s = TERM;
                    end else begin
                        dig_nxt_s   = dig_r - 4'd1;
                        s_dtm_nxt_s = digit_ascii(bcd_r, dig_r - 4'd1);
                    end
                end else begin
                    state_nxt_s = EMIT_DIGITS;
                end
            end
            EMIT_TERM: begin
                if (s_rdy) begin
                    state_nxt_s = IDLE;
                    s_dtm_nxt_s = 8'h00;
                end else begin
                    state_nxt_s = EMIT_TERM;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                s_dtm_nxt_s = 8'h00;
            end
        endcase
        s_vld_nxt_s = (state_nxt_s == EMIT_SIGN) || (state_nxt_s == EMIT_DIGITS) ||
                      (state_nxt_s == EMIT_TERM);
        n_rdy_nxt_s = (state_nxt_s == IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            bin_r   <= 32'd0;
            bcd_r   <= 40'd0;
            cnt_r   <= 5'd0;
            dig_r   <= 4'd0;
            s_dtm_r <= 8'h00;
            s_vld_r <= 1'b0;
            n_rdy_r <= 1'b1;
`ifdef NUM_TO_STR_SIGNED_EN
            neg_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            bin_r   <= bin_nxt_s;
            bcd_r   <= bcd_nxt_s;
            cnt_r   <= cnt_nxt_s;
            dig_r   <= dig_nxt_s;
            s_dtm_r <= s_dtm_nxt_s;
            s_vld_r <= s_vld_nxt_s;
            n_rdy_r <= n_rdy_nxt_s;
`ifdef NUM_TO_STR_SIGNED_EN
            neg_r   <= neg_nxt_s;
`endif
        end
    end

endmodule
